// File: rtl/mem_wb_pkg.sv
// rtl/mem_wb_pkg.sv - shared constants and FSM state type for the MEM/WB stage
package mem_wb_pkg;

    localparam int DW_DEFAULT = 16;
    localparam int RW_DEFAULT = 3;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_wb_state_e;

endpackage

// File: rtl/wb_pipe_reg.sv
// rtl/wb_pipe_reg.sv - write-back packet register with load and bubble controls
module wb_pipe_reg #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          bubble_i,
    input  logic          valid_i,
    input  logic          regwrt_i,
    input  logic          halt_i,
    input  logic [DW-1:0] data_i,
    input  logic [RW-1:0] reg_i,
    output logic          valid_o,
    output logic          regwrt_o,
    output logic          halt_o,
    output logic [DW-1:0] data_o,
    output logic [RW-1:0] reg_o
);

    logic          valid_q;
    logic          regwrt_q;
    logic          halt_q;
    logic [DW-1:0] data_q;
    logic [RW-1:0] reg_q;

    // Load takes a whole packet; a bubble clears only the flags so data/reg keep their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            regwrt_q <= 1'b0;
            halt_q   <= 1'b0;
            data_q   <= '0;
            reg_q    <= '0;
        end else if (load_i) begin
            valid_q  <= valid_i;
            regwrt_q <= regwrt_i;
            halt_q   <= halt_i;
            data_q   <= data_i;
            reg_q    <= reg_i;
        end else if (bubble_i) begin
            valid_q  <= 1'b0;
            regwrt_q <= 1'b0;
            halt_q   <= 1'b0;
        end
    end

    assign valid_o  = valid_q;
    assign regwrt_o = regwrt_q;
    assign halt_o   = halt_q;
    assign data_o   = data_q;
    assign reg_o    = reg_q;

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline stage with multi-cycle memory wait FSM
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int RW = RW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ValidIn,
    input  logic          MemRd,
    input  logic          MemWrt,
    input  logic [DW-1:0] MemOut,
    input  logic [DW-1:0] AluOut,
    input  logic [DW-1:0] PcInc,
    input  logic [1:0]    WbSel,
    input  logic          RegWrtIn,
    input  logic [RW-1:0] WrRegIn,
    input  logic          HaltIn,
    input  logic          MemDone,
    input  logic          MemBusy,
    input  logic          MemErr,
    output logic          StallUp,
    output logic          WbValid,
    output logic [DW-1:0] WbData,
    output logic [RW-1:0] WbReg,
    output logic          WbRegWrt,
    output logic          WbHalt,
    output logic          ErrOut
);

    mem_wb_state_e state_q, state_d;
    logic          access;
    logic          commit;
    logic          err_q, err_d;
    logic [DW-1:0] wb_data_d;

    // Done alone paces the stage; the memory's own stall flag carries no extra information here.
    logic unused_membusy;
    assign unused_membusy = MemBusy;

    assign access  = ValidIn & (MemRd | MemWrt);
    assign StallUp = access & ~MemDone;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and commit decision; a wait that loses its access returns to IDLE rather than hanging.
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!access || MemDone) begin
                    commit = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (MemDone || !access) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write-back source select; the reserved code falls back to the ALU result.
    always_comb begin
        wb_data_d = AluOut;
        case (WbSel)
            WB_MEM:  wb_data_d = MemOut;
            WB_PC:   wb_data_d = PcInc;
            default: wb_data_d = AluOut;
        endcase
    end

    // Sticky error: memory fault or conflicting read+write on an active access.
    assign err_d = err_q | (access & (MemErr | (MemRd & MemWrt)));

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign ErrOut = err_q;

    wb_pipe_reg #(
        .DW (DW),
        .RW (RW)
    ) u_wb_pipe_reg (
        .clk      (clk),
        .rst      (rst),
        .load_i   (commit),
        .bubble_i (~commit),
        .valid_i  (ValidIn),
        .regwrt_i (ValidIn & RegWrtIn),
        .halt_i   (ValidIn & HaltIn),
        .data_i   (wb_data_d),
        .reg_i    (WrRegIn),
        .valid_o  (WbValid),
        .regwrt_o (WbRegWrt),
        .halt_o   (WbHalt),
        .data_o   (WbData),
        .reg_o    (WbReg)
    );

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

    localparam int DW = 16;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          ValidIn, MemRd, MemWrt;
    logic [DW-1:0] MemOut, AluOut, PcInc;
    logic [1:0]    WbSel;
    logic          RegWrtIn;
    logic [RW-1:0] WrRegIn;
    logic          HaltIn, MemDone, MemBusy, MemErr;
    logic          StallUp, WbValid, WbRegWrt, WbHalt, ErrOut;
    logic [DW-1:0] WbData;
    logic [RW-1:0] WbReg;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: last committed data/reg and the sticky error.
    logic [DW-1:0] m_data;
    logic [RW-1:0] m_reg;
    logic          m_err;

    always #5 clk = ~clk;

    mem_wb_stage #(.DW(DW), .RW(RW)) dut (
        .clk      (clk),
        .rst      (rst),
        .ValidIn  (ValidIn),
        .MemRd    (MemRd),
        .MemWrt   (MemWrt),
        .MemOut   (MemOut),
        .AluOut   (AluOut),
        .PcInc    (PcInc),
        .WbSel    (WbSel),
        .RegWrtIn (RegWrtIn),
        .WrRegIn  (WrRegIn),
        .HaltIn   (HaltIn),
        .MemDone  (MemDone),
        .MemBusy  (MemBusy),
        .MemErr   (MemErr),
        .StallUp  (StallUp),
        .WbValid  (WbValid),
        .WbData   (WbData),
        .WbReg    (WbReg),
        .WbRegWrt (WbRegWrt),
        .WbHalt   (WbHalt),
        .ErrOut   (ErrOut)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One instruction: memory accesses see Done after lat cycles; non-accesses commit at once.
    // err_at selects the cycle (0-based) in which MemErr is pulsed, -1 for none.
    task automatic run_instr(input logic v, input logic rd, input logic wr,
                             input logic [DW-1:0] mo, input logic [DW-1:0] alu,
                             input logic [DW-1:0] pc, input logic [1:0] sel,
                             input logic rwe, input logic [RW-1:0] rg, input logic hl,
                             input int lat, input int err_at);
        logic          acc;
        int            eff;
        logic [DW-1:0] exp_d;
        acc = v & (rd | wr);
        eff = acc ? lat : 0;
        ValidIn  = v;
        MemRd    = rd;
        MemWrt   = wr;
        AluOut   = alu;
        PcInc    = pc;
        WbSel    = sel;
        RegWrtIn = rwe;
        WrRegIn  = rg;
        HaltIn   = hl;
        MemBusy  = acc && (eff > 0);
        MemOut   = (eff == 0) ? mo : DW'($urandom);
        MemDone  = acc ? (eff == 0) : ($urandom_range(0, 3) == 0);
        for (int c = 0; c <= eff; c++) begin
            MemErr = (c == err_at);
            #1;
            chk("stall_up", StallUp, (acc && c < eff) ? 1 : 0);
            @(posedge clk);
            #1;
            if (acc && (MemErr || (rd && wr))) m_err = 1'b1;
            if (c < eff) begin
                chk("bubble_valid", WbValid, 0);
                chk("bubble_regwrt", WbRegWrt, 0);
                chk("bubble_halt", WbHalt, 0);
                chk("bubble_data", WbData, m_data);
                chk("bubble_reg", WbReg, m_reg);
            end else begin
                case (sel)
                    2'b01:   exp_d = mo;
                    2'b10:   exp_d = pc;
                    default: exp_d = alu;
                endcase
                m_data = exp_d;
                m_reg  = rg;
                chk("wb_valid", WbValid, v);
                chk("wb_regwrt", WbRegWrt, v & rwe);
                chk("wb_halt", WbHalt, v & hl);
                chk("wb_data", WbData, m_data);
                chk("wb_reg", WbReg, m_reg);
            end
            chk("err_out", ErrOut, m_err);
            @(negedge clk);
            MemErr = 1'b0;
            if (c + 1 == eff) begin
                MemDone = 1'b1;
                MemBusy = 1'b0;
                MemOut  = mo;
            end
        end
        MemDone = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, WbValid, 0);
        chk({tag, "_data"}, WbData, 0);
        chk({tag, "_reg"}, WbReg, 0);
        chk({tag, "_regwrt"}, WbRegWrt, 0);
        chk({tag, "_halt"}, WbHalt, 0);
        chk({tag, "_err"}, ErrOut, 0);
    endtask

    initial begin
        logic rd, wr;
        int   lat;
        rst = 1'b1; ValidIn = 1'b0; MemRd = 1'b0; MemWrt = 1'b0;
        MemOut = '0; AluOut = '0; PcInc = '0; WbSel = 2'b00; RegWrtIn = 1'b0;
        WrRegIn = '0; HaltIn = 1'b0; MemDone = 1'b0; MemBusy = 1'b0; MemErr = 1'b0;
        m_data = '0; m_reg = '0; m_err = 1'b0;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        check_all_zero("reset");
        chk("reset_stall", StallUp, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1 ALU op
        run_instr(1, 0, 0, 16'h0, 16'h1234, 16'h0, 2'b00, 1, 3'd3, 0, 0, -1);
        // 2 Load hit
        run_instr(1, 1, 0, 16'hBEEF, 16'h0100, 16'h0, 2'b01, 1, 3'd1, 0, 0, -1);
        // 3 Load miss, Done after 4 cycles
        run_instr(1, 1, 0, 16'h00A5, 16'h0200, 16'h0, 2'b01, 1, 3'd2, 0, 4, -1);
        // 4 Store miss then ALU op
        run_instr(1, 0, 1, 16'h0, 16'h0300, 16'h0, 2'b00, 0, 3'd4, 0, 3, -1);
        run_instr(1, 0, 0, 16'h0, 16'h5A5A, 16'h0, 2'b00, 1, 3'd6, 0, 0, -1);
        // bubble input and reserved select
        run_instr(0, 1, 0, 16'h0, 16'h7777, 16'h0, 2'b11, 1, 3'd5, 1, 0, -1);
        run_instr(1, 0, 0, 16'h0, 16'h9999, 16'h0, 2'b11, 1, 3'd7, 1, 0, -1);

        // 5 reset during the second WAIT cycle
        ValidIn = 1'b1; MemRd = 1'b1; MemWrt = 1'b0; WbSel = 2'b01; RegWrtIn = 1'b1;
        WrRegIn = 3'd5; HaltIn = 1'b0; MemDone = 1'b0; MemOut = 16'hDEAD;
        #1; chk("rst_wait_stall", StallUp, 1);
        @(posedge clk); #1;
        chk("rst_wait_valid", WbValid, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("rst_wait");
        m_data = '0; m_reg = '0; m_err = 1'b0;
        @(negedge clk);
        rst = 1'b0; ValidIn = 1'b0; MemRd = 1'b0; MemDone = 1'b1; MemOut = 16'h4321;
        #1; chk("rst_after_stall", StallUp, 0);
        @(posedge clk); #1;
        chk("late_done_valid", WbValid, 0);
        chk("late_done_regwrt", WbRegWrt, 0);
        chk("late_done_err", ErrOut, 0);
        m_data = 16'h4321; m_reg = 3'd5;
        chk("late_done_data", WbData, m_data);
        @(negedge clk);
        MemDone = 1'b0;
        // a hit right after reset commits without a stall
        run_instr(1, 1, 0, 16'h1111, 16'h0, 16'h0, 2'b01, 1, 3'd1, 0, 0, -1);

        // 6 MemErr during a miss, then JAL
        run_instr(1, 1, 0, 16'h2222, 16'h0, 16'h0, 2'b01, 1, 3'd2, 0, 3, 1);
        run_instr(1, 0, 0, 16'h0, 16'h0, 16'h0042, 2'b10, 1, 3'd7, 0, 0, -1);
        run_instr(1, 0, 0, 16'h0, 16'h0ABC, 16'h0, 2'b00, 1, 3'd0, 1, 0, -1);

        // clear error and run randomized traffic, including rare read+write conflicts
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("rst_clear");
        m_data = '0; m_reg = '0; m_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            rd  = ($urandom_range(0, 2) == 0);
            wr  = ($urandom_range(0, 3) == 0);
            if (rd && wr && $urandom_range(0, 3) != 0) wr = 1'b0;
            lat = $urandom_range(0, 5);
            run_instr($urandom_range(0, 7) != 0, rd, wr, DW'($urandom), DW'($urandom),
                      DW'($urandom), 2'($urandom), 1'($urandom), RW'($urandom),
                      ($urandom_range(0, 9) == 0),
                      lat, ($urandom_range(0, 24) == 0) ? $urandom_range(0, lat) : -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
